// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (D = load/store, I = fetch), the arbiter and the
// single-port data memory.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // Handshake: a requester raises *_req with its fields and holds all of them stable until it
    // sees the one-cycle *_ready pulse; *_rdata is meaningful only in that cycle. The arbiter
    // drives m_en for exactly one cycle per access, and m_we is qualified by m_en.
    logic                  d_req;
    logic                  d_we;
    logic [1:0]            d_type;
    logic                  d_sign_ext;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  i_req;
    logic [DATA_WIDTH-1:0] i_addr;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  m_en;
    logic                  m_we;
    logic [1:0]            m_type;
    logic                  m_sign_ext;
    logic [DATA_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport slave (
        input  d_req, d_we, d_type, d_sign_ext, d_addr, d_wdata,
        output d_ready, d_rdata,
        input  i_req, i_addr,
        output i_ready, i_rdata,
        output m_en, m_we, m_type, m_sign_ext, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output d_req, d_we, d_type, d_sign_ext, d_addr, d_wdata,
        input  d_ready, d_rdata,
        output i_req, i_addr,
        input  i_ready, i_rdata,
        input  m_en, m_we, m_type, m_sign_ext, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: data port has priority, fetch is
// forced through after MAX_DATA_BURST consecutive data grants while it waits.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_LATENCY    = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_LATENCY - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  gnt_i_q, gnt_i_d;
    logic                  we_q, we_d;
    logic [1:0]            type_q, type_d;
    logic                  sign_q, sign_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  grant_i;

    always_comb begin
        state_d = state_q;
        gnt_i_d = gnt_i_q;
        we_d    = we_q;
        type_d  = type_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        grant_i = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.i_req) begin
                    burst_d = '0;
                end
                if (bus.d_req || bus.i_req) begin
                    // Fetch wins only when data is absent or has used up its burst allowance.
                    grant_i = bus.i_req && !(bus.d_req && (burst_q < BURST_MAX));
                    gnt_i_d = grant_i;
                    state_d = ISSUE;
                    if (grant_i) begin
                        we_d    = 1'b0;
                        type_d  = 2'b10;
                        sign_d  = 1'b0;
                        addr_d  = bus.i_addr;
                        burst_d = '0;
                    end else begin
                        we_d    = bus.d_we;
                        type_d  = bus.d_type;
                        sign_d  = bus.d_sign_ext;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        if (bus.i_req) begin
                            burst_d = burst_q + BW'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                cnt_d   = WAIT_INIT;
                state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.m_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any captured read; a store already issued has reached memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_i_q <= 1'b0;
            we_q    <= 1'b0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_i_q <= gnt_i_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.m_en       = (state_q == ISSUE);
    assign bus.m_we       = bus.m_en & we_q;
    assign bus.m_type     = type_q;
    assign bus.m_sign_ext = sign_q;
    assign bus.m_addr     = addr_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.d_ready    = (state_q == RESP) & ~gnt_i_q;
    assign bus.i_ready    = (state_q == RESP) &  gnt_i_q;
    assign bus.d_rdata    = bus.d_ready ? rdata_q : '0;
    assign bus.i_rdata    = bus.i_ready ? rdata_q : '0;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter with one-cycle and three-cycle memories.
module tb_mem_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW)) bus_a();
    mem_arbiter_if #(.DATA_WIDTH(DW)) bus_b();
    logic [1:0] dbg_a, dbg_b;

    mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(1), .MAX_DATA_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .dbg_state(dbg_a)
    );
    mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(3), .MAX_DATA_BURST(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .dbg_state(dbg_b)
    );

    // Memory contents are a fixed function of address; junk is driven whenever data is not due.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    logic [31:0] pipe_a;
    logic        pv_a = 1'b0;
    always @(posedge clk) begin
        pv_a   <= bus_a.m_en & ~bus_a.m_we;
        pipe_a <= mem_word(bus_a.m_addr);
    end
    assign bus_a.m_rdata = pv_a ? pipe_a : 32'hBADBAD00;

    logic [31:0] pipe_b [3];
    logic [2:0]  pv_b = 3'b000;
    always @(posedge clk) begin
        pv_b      <= {pv_b[1:0], bus_b.m_en & ~bus_b.m_we};
        pipe_b[0] <= mem_word(bus_b.m_addr);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_b.m_rdata = pv_b[2] ? pipe_b[2] : 32'hBADBAD00;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];

    int          n;
    bit          gd, gi;
    bit          d_pend, i_pend, rd_we, exp_i, from_idle;
    int          streak, exp_lat;
    logic [31:0] rd_addr, ri_addr, e;
    int          men_cnt, rdy_cnt, overlap;
    bit          prev_men;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready(input bit sel_b, input int budget, output int cnt,
                              output bit got_d, output bit got_i);
        cnt = 0;
        got_d = 1'b0;
        got_i = 1'b0;
        while (cnt < budget && !got_d && !got_i) begin
            tick();
            cnt++;
            got_d = sel_b ? bus_b.d_ready : bus_a.d_ready;
            got_i = sel_b ? bus_b.i_ready : bus_a.i_ready;
        end
        chk("ready_timeout", 32'(got_d | got_i), 32'd1);
        chk("ready_onehot", 32'(got_d & got_i), 32'd0);
    endtask

    task automatic new_d();
        rd_we           = 1'($urandom_range(0, 1));
        rd_addr         = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        bus_a.d_we      = rd_we;
        bus_a.d_type    = 2'($urandom_range(0, 2));
        bus_a.d_sign_ext = 1'($urandom_range(0, 1));
        bus_a.d_addr    = rd_addr;
        bus_a.d_wdata   = $urandom;
        bus_a.d_req     = 1'b1;
        d_pend          = 1'b1;
    endtask

    task automatic new_i();
        ri_addr      = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        bus_a.i_addr = ri_addr;
        bus_a.i_req  = 1'b1;
        i_pend       = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.d_req = 0; bus_a.d_we = 0; bus_a.d_type = 0; bus_a.d_sign_ext = 0;
        bus_a.d_addr = 0; bus_a.d_wdata = 0; bus_a.i_req = 0; bus_a.i_addr = 0;
        bus_b.d_req = 0; bus_b.d_we = 0; bus_b.d_type = 0; bus_b.d_sign_ext = 0;
        bus_b.d_addr = 0; bus_b.d_wdata = 0; bus_b.i_req = 0; bus_b.i_addr = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_m_en", 32'(bus_a.m_en), 32'd0);
        chk("rst_m_we", 32'(bus_a.m_we), 32'd0);
        chk("rst_d_ready", 32'(bus_a.d_ready), 32'd0);
        chk("rst_i_ready", 32'(bus_a.i_ready), 32'd0);
        chk("rst_m_addr", bus_a.m_addr, 32'd0);

        // Reset held two cycles while a read is in WAIT.
        bus_a.d_we = 0; bus_a.d_type = 2'b10; bus_a.d_addr = 32'h180; bus_a.d_req = 1;
        tick();
        chk("t1_issue", 32'(bus_a.m_en), 32'd1);
        tick();
        rst = 1'b1;
        bus_a.d_req = 0;
        tick();
        chk("t1_rst_m_en", 32'(bus_a.m_en), 32'd0);
        chk("t1_rst_d_ready", 32'(bus_a.d_ready), 32'd0);
        chk("t1_rst_m_addr", bus_a.m_addr, 32'd0);
        tick();
        chk("t1_rst2_d_ready", 32'(bus_a.d_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("t1_after_d_ready", 32'(bus_a.d_ready), 32'd0);
        chk("t1_after_m_en", 32'(bus_a.m_en), 32'd0);

        // Lone load.
        bus_a.d_we = 0; bus_a.d_type = 2'b10; bus_a.d_addr = 32'h100; bus_a.d_req = 1;
        tick();
        chk("t2_m_en", 32'(bus_a.m_en), 32'd1);
        chk("t2_m_we", 32'(bus_a.m_we), 32'd0);
        chk("t2_m_addr", bus_a.m_addr, 32'h100);
        wait_ready(1'b0, 8, n, gd, gi);
        chk("t2_latency", n + 1, 32'd3);
        chk("t2_d_ready", 32'(gd), 32'd1);
        chk("t2_d_rdata", bus_a.d_rdata, 32'hDEADBEEF);
        bus_a.d_req = 0;
        tick();
        chk("t2_single_pulse", 32'(bus_a.d_ready), 32'd0);

        // Lone store.
        bus_a.d_we = 1; bus_a.d_type = 2'b00; bus_a.d_addr = 32'h200;
        bus_a.d_wdata = 32'h12345678; bus_a.d_req = 1;
        tick();
        chk("t3_m_en", 32'(bus_a.m_en), 32'd1);
        chk("t3_m_we", 32'(bus_a.m_we), 32'd1);
        chk("t3_m_addr", bus_a.m_addr, 32'h200);
        chk("t3_m_wdata", bus_a.m_wdata, 32'h12345678);
        chk("t3_m_type", 32'(bus_a.m_type), 32'd0);
        wait_ready(1'b0, 8, n, gd, gi);
        chk("t3_latency", n + 1, 32'd2);
        chk("t3_i_ready", 32'(gi), 32'd0);
        bus_a.d_req = 0;
        tick();

        // Fetch only; address change during WAIT must not reach memory.
        bus_a.i_addr = 32'h40; bus_a.i_req = 1;
        tick();
        chk("t5_m_en", 32'(bus_a.m_en), 32'd1);
        chk("t5_m_type", 32'(bus_a.m_type), 32'd2);
        chk("t5_m_sign_ext", 32'(bus_a.m_sign_ext), 32'd0);
        chk("t5_m_we", 32'(bus_a.m_we), 32'd0);
        chk("t5_m_addr", bus_a.m_addr, 32'h40);
        tick();
        bus_a.i_addr = 32'h80;
        chk("t5_hold_addr", bus_a.m_addr, 32'h40);
        wait_ready(1'b0, 8, n, gd, gi);
        chk("t5_i_ready", 32'(gi), 32'd1);
        chk("t5_i_rdata", bus_a.i_rdata, mem_word(32'h40));
        bus_a.i_req = 0;
        tick();

        // Both ports held: four data grants then one fetch, repeating.
        bus_a.d_we = 0; bus_a.d_type = 2'b10; bus_a.d_addr = 32'h300; bus_a.d_req = 1;
        bus_a.i_addr = 32'h44; bus_a.i_req = 1;
        for (int g = 0; g < 10; g++) exp_q.push_back((g % 5 == 4) ? 32'd1 : 32'd0);
        for (int g = 0; g < 10; g++) begin
            wait_ready(1'b0, 12, n, gd, gi);
            e = exp_q.pop_front();
            chk("t4_grant", 32'(gi), e);
            chk("t4_data", gi ? bus_a.i_rdata : bus_a.d_rdata,
                gi ? mem_word(32'h44) : mem_word(32'h300));
        end
        bus_a.d_req = 0; bus_a.i_req = 0;
        tick();

        // Three-cycle memory: latency and back-to-back isolation.
        bus_b.d_we = 0; bus_b.d_type = 2'b10; bus_b.d_addr = 32'h104; bus_b.d_req = 1;
        tick();
        chk("t6_m_en", 32'(bus_b.m_en), 32'd1);
        wait_ready(1'b1, 12, n, gd, gi);
        chk("t6_latency", n + 1, 32'd5);
        chk("t6_d_rdata", bus_b.d_rdata, mem_word(32'h104));
        bus_b.i_addr = 32'h48; bus_b.i_req = 1;
        men_cnt = 0; rdy_cnt = 0; overlap = 0; prev_men = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus_b.m_en) men_cnt++;
            if (bus_b.d_ready || bus_b.i_ready) rdy_cnt++;
            if (bus_b.m_en && prev_men) overlap++;
            prev_men = bus_b.m_en;
        end
        chk("t6_men_count", men_cnt, 32'd5);
        chk("t6_ready_count", rdy_cnt, 32'd5);
        chk("t6_overlap", overlap, 32'd0);
        bus_b.d_req = 0; bus_b.i_req = 0;

        // Randomized traffic against a grant-order / latency / data model.
        d_pend = 0; i_pend = 0; streak = 0; from_idle = 1;
        tick();
        for (int r = 0; r < 40; r++) begin
            if (!d_pend && $urandom_range(0, 3) != 0) new_d();
            if (!i_pend && $urandom_range(0, 2) != 0) new_i();
            if (!d_pend && !i_pend) new_d();
            exp_i = !(d_pend && (!i_pend || streak < 4));
            if (exp_i) streak = 0;
            else if (i_pend) streak++;
            else streak = 0;
            exp_lat = (from_idle ? 2 : 3) + ((!exp_i && rd_we) ? 0 : 1);
            wait_ready(1'b0, 12, n, gd, gi);
            chk("rnd_port", 32'(gi), 32'(exp_i));
            chk("rnd_latency", n, exp_lat);
            if (exp_i) chk("rnd_i_rdata", bus_a.i_rdata, mem_word(ri_addr));
            else if (!rd_we) chk("rnd_d_rdata", bus_a.d_rdata, mem_word(rd_addr));
            if (exp_i) begin
                i_pend = 0;
                bus_a.i_req = 0;
            end else begin
                d_pend = 0;
                bus_a.d_req = 0;
            end
            from_idle = 0;
        end
        bus_a.d_req = 0; bus_a.i_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
